// File: rtl/occupancy_gate_ctrl.sv
`default_nettype none
// ============================================================================
// occupancy_gate_ctrl - arbitrates entry/exit gates onto a 3-bit occupancy counter
// Revision: 1.0
// ============================================================================
module occupancy_gate_ctrl #(
  parameter int GATE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_req,
  input  logic exit_req,
  input  logic full,
  input  logic empty,
  output logic up,
  output logic down,
  output logic entry_open,
  output logic exit_open,
  output logic entry_deny,
  output logic exit_deny,
  output logic busy
);

  localparam logic [7:0] c_gate_load = 8'(GATE_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPEN_IN  = 3'd1,
    OPEN_OUT = 3'd2,
    COMMIT   = 3'd3,
    SETTLE   = 3'd4,
    DENY     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       entry_armed_q, entry_armed_d;
  logic       exit_armed_q, exit_armed_d;
  logic       last_dir_q, last_dir_d;
  logic       entry_pend, exit_pend, sel_exit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= 8'd0;
      entry_armed_q <= 1'b1;
      exit_armed_q  <= 1'b1;
      last_dir_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      entry_armed_q <= entry_armed_d;
      exit_armed_q  <= exit_armed_d;
      last_dir_q    <= last_dir_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    last_dir_d    = last_dir_q;
    // A low sample re-arms a requester; servicing below disarms it again.
    entry_armed_d = entry_armed_q | ~entry_req;
    exit_armed_d  = exit_armed_q | ~exit_req;
    entry_pend    = entry_req & entry_armed_q;
    exit_pend     = exit_req & exit_armed_q;
    sel_exit      = (entry_pend & exit_pend) ? ~last_dir_q : exit_pend;

    case (state_q)
      IDLE: begin
        if (entry_pend | exit_pend) begin
          last_dir_d = sel_exit;
          if (sel_exit) begin
            exit_armed_d = 1'b0;
            if (empty) begin
              state_d = DENY;
            end else begin
              state_d = OPEN_OUT;
              timer_d = c_gate_load;
            end
          end else begin
            entry_armed_d = 1'b0;
            if (full) begin
              state_d = DENY;
            end else begin
              state_d = OPEN_IN;
              timer_d = c_gate_load;
            end
          end
        end
      end
      OPEN_IN, OPEN_OUT: begin
        timer_d = timer_q - 8'd1;
        if (timer_q == 8'd1) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      DENY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_dir_q holds the direction of the transaction in flight.
  assign busy       = (state_q != IDLE);
  assign entry_open = (state_q == OPEN_IN);
  assign exit_open  = (state_q == OPEN_OUT);
  assign up         = (state_q == COMMIT) & ~last_dir_q;
  assign down       = (state_q == COMMIT) & last_dir_q;
  assign entry_deny = (state_q == DENY) & ~last_dir_q;
  assign exit_deny  = (state_q == DENY) & last_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_occupancy_gate_ctrl.sv
`default_nettype none
// Bench for occupancy_gate_ctrl: counter model plus a transaction-timeline reference.
module tb_occupancy_gate_ctrl;
  localparam int G = 4;
  localparam logic [6:0] V_OPEN_E = 7'b1100000, V_OPEN_X = 7'b1010000,
                         V_UP = 7'b1001000, V_DOWN = 7'b1000100, V_SETTLE = 7'b1000000,
                         V_DENY_E = 7'b1000010, V_DENY_X = 7'b1000001;

  logic clk = 1'b0, reset = 1'b1, entry_req = 1'b0, exit_req = 1'b0;
  logic full_c = 1'b0, empty_c = 1'b1;
  logic up, down, entry_open, exit_open, entry_deny, exit_deny, busy;
  logic [6:0] vec;
  int n_cmp = 0, n_err = 0;

  occupancy_gate_ctrl #(.GATE_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .full(full_c), .empty(empty_c), .up(up), .down(down),
    .entry_open(entry_open), .exit_open(exit_open),
    .entry_deny(entry_deny), .exit_deny(exit_deny), .busy(busy)
  );

  assign vec = {busy, entry_open, exit_open, up, down, entry_deny, exit_deny};
  always #5 clk = ~clk;

  // 3-bit up/down counter with registered flags and alarm on over/underflow.
  logic [2:0] cnt = 3'd0, preset_val = 3'd0;
  logic alarm = 1'b0, preset_en = 1'b0;
  always @(posedge clk) begin
    if (preset_en) begin
      cnt <= preset_val; full_c <= (preset_val == 3'd7); empty_c <= (preset_val == 3'd0);
    end else if (up && down) alarm <= 1'b1;
    else if (up) begin
      if (cnt == 3'd7) alarm <= 1'b1;
      else begin cnt <= cnt + 3'd1; full_c <= (cnt == 3'd6); empty_c <= 1'b0; end
    end else if (down) begin
      if (cnt == 3'd0) alarm <= 1'b1;
      else begin cnt <= cnt - 3'd1; empty_c <= (cnt == 3'd1); full_c <= 1'b0; end
    end
  end

  // Reference: when no transaction is in flight, each edge decides and
  // schedules the whole per-cycle output timeline of the next transaction.
  logic [6:0] exp_q[$];
  logic m_arm_e = 1'b1, m_arm_x = 1'b1, m_last = 1'b1;
  logic pe, px, go_exit, srv_e, srv_x;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete(); m_arm_e = 1'b1; m_arm_x = 1'b1; m_last = 1'b1;
    end else begin
      pe = entry_req & m_arm_e; px = exit_req & m_arm_x; srv_e = 1'b0; srv_x = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      else if (pe | px) begin
        go_exit = (pe & px) ? ~m_last : px;
        m_last = go_exit;
        if (!go_exit) begin
          srv_e = 1'b1;
          if (full_c) exp_q.push_back(V_DENY_E);
          else begin
            repeat (G) exp_q.push_back(V_OPEN_E);
            exp_q.push_back(V_UP); exp_q.push_back(V_SETTLE);
          end
        end else begin
          srv_x = 1'b1;
          if (empty_c) exp_q.push_back(V_DENY_X);
          else begin
            repeat (G) exp_q.push_back(V_OPEN_X);
            exp_q.push_back(V_DOWN); exp_q.push_back(V_SETTLE);
          end
        end
      end
      m_arm_e = (m_arm_e | ~entry_req) & ~srv_e;
      m_arm_x = (m_arm_x | ~exit_req) & ~srv_x;
    end
  end

  function automatic logic [6:0] exp_now();
    return (exp_q.size() != 0) ? exp_q[0] : 7'b0;
  endfunction

  task automatic set_count(input logic [2:0] v);
    @(negedge clk); preset_val = v; preset_en = 1'b1;
    @(negedge clk); preset_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (vec !== 7'b0) begin n_err++; $display("FAIL reset_hold: got %b expected %b", vec, 7'b0); end
    set_count(3'd0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now()) begin n_err++; $display("FAIL reset_idle: got %b expected %b", vec, exp_now()); end
    end
  endtask

  task automatic test_single_entry();
    int opens = 0, ups = 0;
    set_count(3'd0);
    @(negedge clk); entry_req = 1'b1;
    repeat (20) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now()) begin n_err++; $display("FAIL single_entry_cyc: got %b expected %b", vec, exp_now()); end
      opens += int'(entry_open); ups += int'(up);
    end
    entry_req = 1'b0;
    @(negedge clk); n_cmp++;
    if (opens != G || ups != 1 || cnt != 3'd1 || empty_c !== 1'b0) begin
      n_err++; $display("FAIL single_entry_sum: got opens=%0d ups=%0d cnt=%0d empty=%b expected %0d 1 1 0", opens, ups, cnt, empty_c, G);
    end
  endtask

  task automatic test_deny_full();
    int denies = 0, ups = 0, opens = 0;
    set_count(3'd7);
    entry_req = 1'b1;
    repeat (6) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now()) begin n_err++; $display("FAIL deny_full_cyc: got %b expected %b", vec, exp_now()); end
      denies += int'(entry_deny); ups += int'(up); opens += int'(entry_open);
    end
    entry_req = 1'b0;
    n_cmp++;
    if (denies != 1 || ups != 0 || opens != 0 || alarm !== 1'b0 || cnt != 3'd7) begin
      n_err++; $display("FAIL deny_full_sum: got deny=%0d up=%0d open=%0d alarm=%b cnt=%0d expected 1 0 0 0 7", denies, ups, opens, alarm, cnt);
    end
  endtask

  task automatic test_deny_empty();
    int denies = 0, downs = 0;
    set_count(3'd0);
    exit_req = 1'b1;
    repeat (6) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now()) begin n_err++; $display("FAIL deny_empty_cyc: got %b expected %b", vec, exp_now()); end
      denies += int'(exit_deny); downs += int'(down);
    end
    exit_req = 1'b0;
    n_cmp++;
    if (denies != 1 || downs != 0 || cnt != 3'd0) begin
      n_err++; $display("FAIL deny_empty_sum: got deny=%0d down=%0d cnt=%0d expected 1 0 0", denies, downs, cnt);
    end
  endtask

  task automatic test_alternate();
    int order[$];
    logic [2:0] cnts[$];
    logic raise_e = 1'b0, raise_x = 1'b0, rec = 1'b0;
    set_count(3'd3);
    @(negedge clk); entry_req = 1'b1; exit_req = 1'b1;
    repeat (45) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now() || (up && down)) begin n_err++; $display("FAIL alternate_cyc: got %b expected %b", vec, exp_now()); end
      if (rec) cnts.push_back(cnt);
      rec = 1'b0;
      if (raise_e) begin entry_req = 1'b1; raise_e = 1'b0; end
      if (raise_x) begin exit_req = 1'b1; raise_x = 1'b0; end
      if (up || down) begin
        order.push_back(down ? 1 : 0); rec = 1'b1;
        if (order.size() < 4) begin
          if (up) begin entry_req = 1'b0; raise_e = 1'b1; end
          else begin exit_req = 1'b0; raise_x = 1'b1; end
        end else begin entry_req = 1'b0; exit_req = 1'b0; end
      end
    end
    n_cmp++;
    if (order.size() != 4 || cnts.size() != 4) begin
      n_err++; $display("FAIL alternate_count: got %0d services expected 4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (order[k] != k % 2 || cnts[k] != ((k % 2 == 0) ? 3'd4 : 3'd3)) begin
          n_err++; $display("FAIL alternate_order[%0d]: got dir=%0d cnt=%0d expected dir=%0d cnt=%0d", k, order[k], cnts[k], k % 2, (k % 2 == 0) ? 4 : 3);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ups = 0, denies = 0;
    logic settle_next = 1'b0;
    set_count(3'd6);
    entry_req = 1'b1;
    repeat (25) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now()) begin n_err++; $display("FAIL b2b_cyc: got %b expected %b", vec, exp_now()); end
      if (settle_next) begin
        n_cmp++;
        if (full_c !== 1'b1 || cnt != 3'd7 || vec !== V_SETTLE) begin
          n_err++; $display("FAIL b2b_settle_full: got full=%b cnt=%0d vec=%b expected 1 7 %b", full_c, cnt, vec, V_SETTLE);
        end
        settle_next = 1'b0; entry_req = 1'b1;
      end
      if (up) begin ups++; entry_req = 1'b0; settle_next = 1'b1; end
      if (entry_deny) begin denies++; entry_req = 1'b0; end
    end
    entry_req = 1'b0;
    n_cmp++;
    if (ups != 1 || denies != 1 || alarm !== 1'b0) begin
      n_err++; $display("FAIL b2b_sum: got ups=%0d denies=%0d alarm=%b expected 1 1 0", ups, denies, alarm);
    end
  endtask

  task automatic test_reset_mid();
    int ups = 0;
    logic found = 1'b0;
    set_count(3'd2);
    entry_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (entry_open) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL reset_mid_open: got no entry_open expected one within 10 cycles"); end
    @(negedge clk); #2 reset = 1'b1;
    #1 n_cmp++;
    if (vec !== 7'b0) begin n_err++; $display("FAIL reset_mid_async: got %b expected %b", vec, 7'b0); end
    @(negedge clk); n_cmp++;
    if (vec !== 7'b0 || cnt != 3'd2) begin n_err++; $display("FAIL reset_mid_hold: got vec=%b cnt=%0d expected 0 2", vec, cnt); end
    reset = 1'b0;
    repeat (15) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now()) begin n_err++; $display("FAIL reset_mid_cyc: got %b expected %b", vec, exp_now()); end
      ups += int'(up);
    end
    entry_req = 1'b0;
    n_cmp++;
    if (ups != 1 || cnt != 3'd3) begin n_err++; $display("FAIL reset_mid_resume: got ups=%0d cnt=%0d expected 1 3", ups, cnt); end
  endtask

  task automatic test_random();
    repeat (400) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now() || (up && down)) begin n_err++; $display("FAIL random_cyc: got %b expected %b", vec, exp_now()); end
      if ($urandom_range(0, 3) == 0) entry_req = ~entry_req;
      if ($urandom_range(0, 3) == 0) exit_req = ~exit_req;
    end
    entry_req = 1'b0; exit_req = 1'b0;
    repeat (10) begin
      @(negedge clk); n_cmp++;
      if (vec !== exp_now()) begin n_err++; $display("FAIL random_drain: got %b expected %b", vec, exp_now()); end
    end
    n_cmp++;
    if (alarm !== 1'b0) begin n_err++; $display("FAIL random_alarm: got %b expected 0", alarm); end
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_deny_full();
    test_deny_empty();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/occupancy_gate_ctrl.md
# occupancy_gate_ctrl

Sequencing controller that sits in front of the 3-bit up/down occupancy counter and shares it between two requesters: an entry gate and an exit gate. It grants one gate at a time and holds that gate open for a fixed number of cycles. It then commits exactly one `up` or `down` pulse to the counter and waits for the counter's flags to settle. Entry requests are refused while the counter reports full, and exit requests while it reports empty, so the counter is never driven into its alarm condition.

## Interface
Parameters:
- `GATE_CYCLES`, default 4: cycles a granted gate stays open; legal range 1..255.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `entry_req`  in  1  level request from the entry gate.
- `exit_req`  in  1  level request from the exit gate.
- `full`  in  1  counter `Full_Flag`, registered by the counter.
- `empty`  in  1  counter `Empty_Flag`, registered by the counter.
- `up`  out  1  one-cycle increment pulse to the counter.
- `down`  out  1  one-cycle decrement pulse to the counter.
- `entry_open`  out  1  entry gate open.
- `exit_open`  out  1  exit gate open.
- `entry_deny`  out  1  one-cycle refusal, counter full.
- `exit_deny`  out  1  one-cycle refusal, counter empty.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, OPEN_IN, OPEN_OUT, COMMIT, SETTLE, DENY.
- All outputs are Moore decodes of registered state.
- 8-bit gate timer.
- Per-requester `armed` bit; 1-bit `last_dir` (0 = entry, 1 = exit).

Request handling:
- A request is *pending* when its req input is 1 and its `armed` bit is 1.
- Servicing a request, whether granted or denied, clears its `armed` bit.
- `armed` sets again only after the req input is sampled 0.
- A req held high is therefore serviced exactly once.

IDLE:
- With no pending request, remain in IDLE.
- With one pending request, select it.
- With both pending, select the direction opposite `last_dir`.
- Selected entry with `full`=1 → DENY (entry). Otherwise → OPEN_IN, timer = GATE_CYCLES.
- Selected exit with `empty`=1 → DENY (exit). Otherwise → OPEN_OUT, timer = GATE_CYCLES.
- `last_dir` takes the selected direction on both grants and denies.

Other states:
- OPEN_IN / OPEN_OUT: the matching `*_open` is 1. Timer decrements each cycle; when the timer reaches 1 → COMMIT.
- COMMIT: `up` (entry) or `down` (exit) is 1 for exactly one cycle → SETTLE.
- SETTLE: one cycle with no pulses, so the counter flags reflect the new count → IDLE.
- DENY: the matching `*_deny` is 1 for one cycle → IDLE.

Boundary behaviour:
- `up` and `down` are never 1 together.
- Never more than one pulse per transaction.
- A req dropping during OPEN_*: the transaction still completes and commits.
- Entry pulse when the counter is at 6 produces `full`=1, which becomes visible in SETTLE. A following entry in IDLE is then denied.
- Reset at any time: state IDLE, all outputs 0, timer 0, `armed`=1 for both, `last_dir`=1 (entry wins the first tie).
- Reset during OPEN_* aborts the transaction and issues no pulse.

## Timing
- Request sampled 1 at IDLE edge t0: `*_open`=1 during cycles t0+1 .. t0+GATE_CYCLES.
- Pulse is high during cycle t0+GATE_CYCLES+1.
- SETTLE occupies cycle t0+GATE_CYCLES+2.
- First edge at which a new request can be accepted: t0+GATE_CYCLES+3.
- Denial: `*_deny`=1 during cycle t0+1; next request can be accepted at edge t0+2.
- `busy` covers exactly the cycles in which state is not IDLE.
- `full`/`empty` are sampled only in IDLE.

## Test plan
- Reset, counter at 0, `entry_req`=1 held for 20 cycles (GATE_CYCLES=4) → `entry_open` high for 4 cycles, then one `up` pulse. Counter goes to 1, `empty` drops, and no second transaction occurs.
- Counter filled to 7, new entry request → `entry_deny` for 1 cycle, no `up`, `entry_open` stays 0, counter `Alarm_Flag` stays 0.
- Counter at 0, exit request → `exit_deny` for 1 cycle, no `down`, count stays 0.
- Counter at 3, `entry_req` and `exit_req` both rising together and held, each toggled low/high after service (three re-assertions) → service order entry, exit, entry, exit. Counter sequence 4, 3, 4, 3; `up` and `down` never overlap.
- `reset` pulsed during the 2nd `entry_open` cycle → all outputs 0 immediately, no `up`, count unchanged. A held `entry_req` is serviced again after reset release.
- Counter at 6, two entry requests back-to-back → first grants (count 7, `full`=1 visible in SETTLE), second denied.
